// File: rtl/lif_pkg.sv
// lif_pkg: shared definitions for the leaky integrate-and-fire layer.
//   - lif_rst_mode_e : what happens to the membrane after a spike
//   - lif_sat_add    : unsigned add that clamps to the all-ones value of a
//                      chosen width instead of wrapping
package lif_pkg;

  // Post-spike membrane behaviour: clear to zero, or keep the excess above threshold.
  typedef enum logic {
    LIF_RST_ZERO = 1'b0,
    LIF_RST_SUB  = 1'b1
  } lif_rst_mode_e;

  // Saturating add of two operands already known to fit in w bits (w <= 32).
  // The sum is formed one bit wider so the carry is visible, then clamped.
  function automatic logic [31:0] lif_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned w);
    logic [32:0] sum_v;
    logic [32:0] lim_v;
    sum_v = {1'b0, a} + {1'b0, b};
    lim_v = (33'd1 << w) - 33'd1;
    if (sum_v > lim_v) begin
      return lim_v[31:0];
    end else begin
      return sum_v[31:0];
    end
  endfunction

endpackage

// File: rtl/lif_cell.sv
// lif_cell: one leaky integrate-and-fire neuron.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en          - advance state when 1, hold when 0
//   in_cur      - input current for this step
//   thresh      - firing threshold
//   s_out       - registered membrane value
//   spike_out   - registered spike flag (one cycle per firing)
//   spike_nxt   - value spike_out takes at the next edge (for counters
//                 that must count in the same edge as the spike appears)
module lif_cell
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_cur,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] s_out,
  output logic             spike_out,
  output logic             spike_nxt
);

  // The refractory counter needs at least one bit even when REFRAC is 0.
  localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RC_W-1:0] REFRAC_V = RC_W'(REFRAC);

  logic [WIDTH-1:0] s_q, s_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             spike_q, spike_d;
  logic [WIDTH-1:0] leaked_s;

  // s - (s >> LEAK_SHIFT) never underflows, so no guard is needed here.
  assign leaked_s = s_q - (s_q >> LEAK_SHIFT);

  // Next-state: refractory first, then fire, then leak+integrate.
  always_comb begin
    s_d     = s_q;
    rc_d    = rc_q;
    spike_d = spike_q;
    if (en) begin
      if (rc_q != {RC_W{1'b0}}) begin
        s_d     = {WIDTH{1'b0}};
        rc_d    = rc_q - RC_W'(1);
        spike_d = 1'b0;
      end else if (s_q >= thresh) begin
        spike_d = 1'b1;
        rc_d    = REFRAC_V;
        if (RESET_MODE == int'(LIF_RST_SUB)) begin
          s_d = s_q - thresh;
        end else begin
          s_d = {WIDTH{1'b0}};
        end
      end else begin
        spike_d = 1'b0;
        rc_d    = rc_q;
        s_d     = WIDTH'(lif_sat_add(32'(leaked_s), 32'(in_cur), WIDTH));
      end
    end else begin
      s_d     = s_q;
      rc_d    = rc_q;
      spike_d = spike_q;
    end
  end

  // Neuron state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= {WIDTH{1'b0}};
      rc_q    <= {RC_W{1'b0}};
      spike_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      rc_q    <= rc_d;
      spike_q <= spike_d;
    end
  end

  assign s_out     = s_q;
  assign spike_out = spike_q;
  assign spike_nxt = spike_d;

endmodule

// File: rtl/lif_layer.sv
// lif_layer: feed-forward chain of N leaky integrate-and-fire neurons.
// Neuron 0 integrates `current`; neuron k>0 receives WEIGHT in the step
// after neuron k-1 spikes.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - advance all state when 1, freeze everything when 0
//   current    - input current of neuron 0
//   thresh     - firing threshold shared by all neurons
//   sel        - neuron whose membrane appears on state_out (>= N gives 0)
//   cnt_clr    - synchronous clear of spike_cnt (only acts when en=1)
//   spike      - registered spike flags, bit k = neuron k
//   state_out  - membrane of neuron sel
//   spike_cnt  - saturating count of last-neuron spike cycles
module lif_layer
  import lif_pkg::*;
#(
  parameter int               N          = 4,
  parameter int               WIDTH      = 8,
  parameter int               LEAK_SHIFT = 1,
  parameter int               REFRAC     = 2,
  parameter logic [WIDTH-1:0] WEIGHT     = 8'd255,
  parameter int               RESET_MODE = 0,
  parameter int               CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     current,
  input  logic [WIDTH-1:0]     thresh,
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 cnt_clr,
  output logic [N-1:0]         spike,
  output logic [WIDTH-1:0]     state_out,
  output logic [CNT_W-1:0]     spike_cnt
);

  logic [WIDTH-1:0] s_arr  [N];
  logic [WIDTH-1:0] in_arr [N];
  logic [N-1:0]     spike_nxt_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar k = 0; k < N; k++) begin : g_cell
    if (k == 0) begin : g_head
      assign in_arr[k] = current;
    end else begin : g_link
      // Chaining uses the registered spike, which gives the 2-cycle stage delay.
      assign in_arr[k] = spike[k-1] ? WEIGHT : {WIDTH{1'b0}};
    end

    lif_cell #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC),
      .RESET_MODE (RESET_MODE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_cur    (in_arr[k]),
      .thresh    (thresh),
      .s_out     (s_arr[k]),
      .spike_out (spike[k]),
      .spike_nxt (spike_nxt_s[k])
    );
  end

  // Membrane readout mux; out-of-range selects read as zero.
  always_comb begin
    state_out = {WIDTH{1'b0}};
    if (int'(sel) < N) begin
      state_out = s_arr[sel];
    end else begin
      state_out = {WIDTH{1'b0}};
    end
  end

  // Counter next-state: clear beats increment; counts on the edge the spike is registered.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_clr) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (spike_nxt_s[N-1] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Spike counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_layer.sv
// tb_lif_layer: self-checking bench for lif_layer.
// Instance A: N=4, reset-to-zero, REFRAC=2, CNT_W=2.
// Instance B: N=3, subtract-threshold, REFRAC=0, CNT_W=8.
module tb_lif_layer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] cur_a, thr_a, cur_b, thr_b;
  logic [1:0] sel_a, sel_b;
  logic       clr_a, clr_b;
  logic [3:0] spike_a;
  logic [7:0] state_a;
  logic [1:0] cnt_a;
  logic [2:0] spike_b;
  logic [7:0] state_b;
  logic [7:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  // Behavioural reference state, index [instance][neuron].
  int ms   [2][4];
  int mrc  [2][4];
  bit msp  [2][4];
  int mcnt [2];

  typedef struct {
    logic [3:0] sp_a;
    logic [7:0] st_a;
    logic [1:0] cnt_a;
    logic [2:0] sp_b;
    logic [7:0] st_b;
    logic [7:0] cnt_b;
  } exp_t;
  exp_t sb_q[$];

  lif_layer #(
    .N(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2), .WEIGHT(8'd255),
    .RESET_MODE(0), .CNT_W(2)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .current(cur_a), .thresh(thr_a),
    .sel(sel_a), .cnt_clr(clr_a), .spike(spike_a), .state_out(state_a),
    .spike_cnt(cnt_a)
  );

  lif_layer #(
    .N(3), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(0), .WEIGHT(8'd255),
    .RESET_MODE(1), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .current(cur_b), .thresh(thr_b),
    .sel(sel_b), .cnt_clr(clr_b), .spike(spike_b), .state_out(state_b),
    .spike_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", tag, edge_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        ms[i][k] = 0; mrc[i][k] = 0; msp[i][k] = 1'b0;
      end
      mcnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int cur, input int thr, input bit clr);
    int n, refr, cmax, inp, v;
    bit mode_sub;
    bit osp[4];
    n        = (i == 0) ? 4 : 3;
    refr     = (i == 0) ? 2 : 0;
    mode_sub = (i == 1);
    cmax     = (i == 0) ? 3 : 255;
    if (!en) return;
    for (int k = 0; k < 4; k++) osp[k] = msp[i][k];
    for (int k = 0; k < n; k++) begin
      inp = (k == 0) ? cur : (osp[k-1] ? 255 : 0);
      if (mrc[i][k] != 0) begin
        ms[i][k] = 0; mrc[i][k] = mrc[i][k] - 1; msp[i][k] = 1'b0;
      end else if (ms[i][k] >= thr) begin
        msp[i][k] = 1'b1; mrc[i][k] = refr;
        ms[i][k] = mode_sub ? (ms[i][k] - thr) : 0;
      end else begin
        v = ms[i][k] - ms[i][k] / 2 + inp;
        ms[i][k] = (v > 255) ? 255 : v;
        msp[i][k] = 1'b0;
      end
    end
    if (clr) mcnt[i] = 0;
    else if (msp[i][n-1] && mcnt[i] < cmax) mcnt[i] = mcnt[i] + 1;
  endtask

  function automatic int ex_state(input int i, input int s);
    int n;
    n = (i == 0) ? 4 : 3;
    return (s < n) ? ms[i][s] : 0;
  endfunction

  // One enabled/disabled clock step: predict, push, clock, pop, compare.
  task automatic tick();
    exp_t e, g;
    model_step(0, int'(cur_a), int'(thr_a), clr_a);
    model_step(1, int'(cur_b), int'(thr_b), clr_b);
    for (int k = 0; k < 4; k++) e.sp_a[k] = msp[0][k];
    for (int k = 0; k < 3; k++) e.sp_b[k] = msp[1][k];
    e.st_a  = 8'(ex_state(0, int'(sel_a)));
    e.st_b  = 8'(ex_state(1, int'(sel_b)));
    e.cnt_a = 2'(mcnt[0]);
    e.cnt_b = 8'(mcnt[1]);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    edge_no++;
    g = sb_q.pop_front();
    check_val("spike_a", 32'(spike_a), 32'(g.sp_a));
    check_val("state_a", 32'(state_a), 32'(g.st_a));
    check_val("cnt_a",   32'(cnt_a),   32'(g.cnt_a));
    check_val("spike_b", 32'(spike_b), 32'(g.sp_b));
    check_val("state_b", 32'(state_b), 32'(g.st_b));
    check_val("cnt_b",   32'(cnt_b),   32'(g.cnt_b));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    #1;
    edge_no = 0;
  endtask

  task automatic randomize_b();
    cur_b = 8'($urandom_range(0, 255));
    thr_b = 8'($urandom_range(0, 255));
    sel_b = 2'($urandom_range(0, 3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp[8];
    lp = '{100, 150, 175, 188, 194, 197, 199, 200};
    rst = 1'b1; en = 1'b1;
    cur_a = 8'd0; thr_a = 8'd0; sel_a = 2'd0; clr_a = 1'b0;
    cur_b = 8'd0; thr_b = 8'd0; sel_b = 2'd0; clr_b = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("rst_spike_a", 32'(spike_a), 32'd0);
    check_val("rst_state_a", 32'(state_a), 32'd0);
    check_val("rst_cnt_a",   32'(cnt_a),   32'd0);
    check_val("rst_spike_b", 32'(spike_b), 32'd0);
    check_val("rst_cnt_b",   32'(cnt_b),   32'd0);
    rst = 1'b0;

    // Leak/integrate, spike, refractory, chain; B runs subtract mode.
    cur_a = 8'd100; thr_a = 8'd200;
    cur_b = 8'd100; thr_b = 8'd255;
    for (int t = 1; t <= 15; t++) begin
      if (t == 9) thr_b = 8'd150;
      tick();
      if (t <= 8) begin
        check_val("leak_a", 32'(state_a), 32'(lp[t-1]));
        check_val("leak_b", 32'(state_b), 32'(lp[t-1]));
      end else begin
        case (t)
          9: begin
            check_val("fire_spike_a", 32'(spike_a), 32'd1);
            check_val("fire_state_a", 32'(state_a), 32'd0);
            check_val("sub_state_b",  32'(state_b), 32'd50);
            check_val("sub_spike_b0", 32'(spike_b[0]), 32'd1);
          end
          10: begin
            check_val("refrac1_a", 32'(state_a), 32'd0);
            check_val("sub_next_b", 32'(state_b), 32'd125);
          end
          11: begin
            check_val("refrac2_a", 32'(state_a), 32'd0);
            check_val("chain1_a",  32'(spike_a), 32'd2);
          end
          12: check_val("resume_a", 32'(state_a), 32'd100);
          15: begin
            check_val("chain_last_a", 32'(spike_a), 32'd8);
            check_val("cnt_first_a",  32'(cnt_a),   32'd1);
          end
          default: ;
        endcase
      end
    end

    // Saturation, then an asynchronous reset during refractory.
    pulse_reset();
    cur_a = 8'd255; thr_a = 8'd255;
    randomize_b();
    tick();
    check_val("sat_state_a", 32'(state_a), 32'd255);
    randomize_b();
    tick();
    check_val("sat_spike_a", 32'(spike_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_spike_a", 32'(spike_a), 32'd0);
    check_val("midrst_state_a", 32'(state_a), 32'd0);
    check_val("midrst_cnt_a",   32'(cnt_a),   32'd0);
    check_val("midrst_spike_b", 32'(spike_b), 32'd0);
    check_val("midrst_cnt_b",   32'(cnt_b),   32'd0);
    model_reset();
    rst = 1'b0;
    randomize_b();
    tick();
    check_val("no_refrac_a", 32'(state_a), 32'd255);

    // Repeated last-neuron spikes saturate the 2-bit counter.
    thr_a = 8'd1;
    for (int t = 0; t < 24; t++) begin
      sel_a = 2'($urandom_range(0, 3));
      randomize_b();
      tick();
    end
    check_val("cnt_sat_a", 32'(cnt_a), 32'd3);
    clr_a = 1'b1;
    for (int t = 0; t < 4; t++) begin
      randomize_b();
      tick();
    end
    check_val("cnt_clr_a", 32'(cnt_a), 32'd0);
    clr_a = 1'b0;
    for (int t = 0; t < 6; t++) begin
      randomize_b();
      tick();
    end
    // Hold with clear requested: clear must be ignored while disabled.
    en = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
    for (int t = 0; t < 5; t++) begin
      randomize_b();
      tick();
    end
    en = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    for (int t = 0; t < 3; t++) begin
      randomize_b();
      tick();
    end

    // Enable low mid-integration freezes the membrane.
    pulse_reset();
    cur_a = 8'd100; thr_a = 8'd200; sel_a = 2'd0;
    for (int t = 0; t < 3; t++) begin
      randomize_b();
      tick();
    end
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      randomize_b();
      tick();
      check_val("hold_state_a", 32'(state_a), 32'd175);
    end
    en = 1'b1;
    randomize_b();
    tick();
    check_val("after_hold_a", 32'(state_a), 32'd188);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lif_layer.md
# lif_layer

Parametrised layer of leaky integrate-and-fire neurons, wired as a feed-forward chain. Neuron 0 integrates an external current. Each later neuron integrates a fixed synaptic weight whenever its predecessor spikes. Adds a programmable threshold, a selectable reset mode, a refractory period, a muxed state readout and a saturating spike counter on the last neuron. It sits directly behind the top-level pin wrapper, in place of a hand-wired pair of single neurons.

## Interface
- `N`, 4: number of neurons in the chain (≥2)
- `WIDTH`, 8: membrane, current and threshold width
- `LEAK_SHIFT`, 1: leak per step = s >> LEAK_SHIFT
- `REFRAC`, 2: refractory cycles after a spike (0 = none)
- `WEIGHT`, 8'd255: input to neuron k>0 when spike[k-1]=1
- `RESET_MODE`, 0: 0 = reset to zero, 1 = subtract threshold
- `CNT_W`, 8: spike counter width
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: advance all state when 1, hold everything when 0
- `current` in WIDTH: input current to neuron 0
- `thresh` in WIDTH: firing threshold shared by all neurons
- `sel` in $clog2(N): neuron selected for `state_out`
- `cnt_clr` in 1: synchronous clear of `spike_cnt`
- `spike` out N: registered spike flags, bit k = neuron k
- `state_out` out WIDTH: membrane of neuron `sel` (combinational mux of registers)
- `spike_cnt` out CNT_W: count of spike[N-1] assertions, saturating

## Operation
- Per neuron, registers are s (WIDTH bits), rc (refractory count) and spike_q.
- Input to neuron 0 is `current`. Input to neuron k is WEIGHT if spike_q[k-1] else 0.
- Rule at each clk edge with en=1, first match wins:
  - rc≠0: s←0, rc←rc−1, spike_q←0. Input is discarded.
  - s≥thresh: spike_q←1, rc←REFRAC. s←0 when RESET_MODE=0; s←s−thresh when RESET_MODE=1.
  - otherwise: spike_q←0, s←sat(s − (s>>LEAK_SHIFT) + in).
- Arithmetic: sum is computed in WIDTH+1 bits. A result above 2^WIDTH−1 clamps to all-ones. No wrap-around anywhere.
- thresh=0: every non-refractory cycle fires.
- Spike counter:
  - increments on edges where en=1 and spike_q[N-1]=1 after the update, i.e. one count per spike cycle
  - saturates at all-ones
  - cnt_clr=1 with en=1 clears it; clear wins over a simultaneous increment
  - cnt_clr is ignored when en=0
- en=0: all s, rc, spike_q and counter values hold, and outputs stay stable.
- sel ≥ N: state_out = 0.

## Timing
- Reset values: s=0, rc=0, spike=0, spike_cnt=0, state_out=0.
- Reset applies immediately, independent of clk, and may arrive mid-refractory or mid-chain. After release, operation starts clean on the next enabled edge.
- Spike latency: a neuron whose s≥thresh at edge t shows spike=1 after edge t, for exactly one cycle. The following REFRAC edges hold s=0.
- Chain latency: spike[k-1] high in cycle t adds WEIGHT at edge t+1. With WEIGHT≥thresh, spike[k] rises one edge after that. Net stage delay is 2 cycles.
- Neuron 0 and neuron k may spike in the same cycle; there is no arbitration.

## Structure
- Package `lif_pkg`:
  - RESET_MODE encodings LIF_RST_ZERO / LIF_RST_SUB
  - saturating add function
- Sub-module `lif_cell`:
  - contains one neuron: s, rc, spike_q, leak, saturation and reset mode
  - parameters WIDTH, LEAK_SHIFT, REFRAC, RESET_MODE
- Top-level `lif_layer`:
  - generates N cells and the weight chaining
  - contains the sel mux and the spike counter

## Test plan
- Leak/integrate, with WIDTH=8, LEAK_SHIFT=1, REFRAC=2, thresh=200, current=100, en=1:
  - neuron-0 s goes 100,150,175,188,194,197,199,200 on edges 1–8
  - spike[0]=1 after edge 9, with s=0
  - s=0 after edges 10–11; s=100 after edge 12
- Saturation: current=255, thresh=255 → s=255 after edge 1 (not 0); spike[0]=1 after edge 2.
- Chain, WEIGHT=255: the spike[0] pulse from the leak test → spike[1]=1 exactly 2 cycles later; spike[N-1] arrives 2·(N−1) cycles after spike[0].
- Subtract mode, RESET_MODE=1, REFRAC=0, thresh=150:
  - with s=200 at a firing edge → s=50 and spike=1
  - the next edge integrates from 50
- Enable/reset:
  - en=0 for 5 cycles mid-integration → s, spike and counter are unchanged
  - rst pulsed between edges during refractory → all outputs 0 before the next edge, with no residual refractory
- Counter: drive repeated spike[N-1] pulses with CNT_W=2 → counts 1,2,3,3 (saturated); cnt_clr asserted in a spike cycle → 0.
